// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        RESP
    } state_t;

    typedef logic client_t;

    localparam int MUL_LAT_DEFAULT = 18;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the client not granted last.
// Single-cycle combinational grant; the last-grant pointer updates whenever a grant is issued.
module rr_arb2
    import mult_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output client_t    gnt_idx
);

    client_t last;

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt     = 2'b01;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt     = 2'b10;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt     = last ? 2'b01 : 2'b10;
                    gnt_idx = ~last;
                end
                default: begin
                    gnt     = 2'b00;
                    gnt_idx = 1'b0;
                end
            endcase
        end
    end

    // Reset to client 1 so client 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// mult_sched: two-client scheduler for the shared shift-add multiplier; grant to response is MUL_LAT+3 cycles.
// Response is held until the owner's Rsp_Ready; MULT_SCHED_ZERO_BYPASS_EN lets zero-operand jobs skip the multiplier.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [7:0]  Opa0,
    input  logic [7:0]  Opb0,
    input  logic [7:0]  Opa1,
    input  logic [7:0]  Opb1,
    output logic        Req_Ack0,
    output logic        Req_Ack1,
    output logic        Rsp_Valid0,
    output logic        Rsp_Valid1,
    input  logic        Rsp_Ready0,
    input  logic        Rsp_Ready1,
    output logic [15:0] Rsp_Prod,
    output logic [7:0]  Mul_Opa,
    output logic [7:0]  Mul_Opb,
    output logic        Mul_LoadB,
    output logic        Mul_Run,
    input  logic [15:0] Mul_Prod
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    client_t       owner;
    logic [1:0]    gnt;
    client_t       gnt_idx;
    logic          acked;
    logic          handshake;
    logic          arb_en;
    logic          zero_job;

    assign acked     = Req_Ack0 | Req_Ack1;
    assign handshake = (state == RESP) && (owner ? Rsp_Ready1 : Rsp_Ready0);
    // Arbitrating on the handshake cycle lets a registered ack land in the first IDLE cycle.
    assign arb_en    = ((state == IDLE) && !acked) || handshake;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
    assign zero_job = (Mul_Opa == 8'd0) || (Mul_Opb == 8'd0);
`else
    assign zero_job = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk     (Clk),
        .reset   (Reset),
        .req     ({Req1, Req0}),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acked) state_nxt = zero_job ? RESP : LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            Req_Ack0 <= 1'b0;
            Req_Ack1 <= 1'b0;
            Rsp_Prod <= '0;
            Mul_Opa  <= '0;
            Mul_Opb  <= '0;
        end else begin
            state    <= state_nxt;
            Req_Ack0 <= gnt[0];
            Req_Ack1 <= gnt[1];
            if (|gnt) begin
                owner   <= gnt_idx;
                Mul_Opa <= gnt_idx ? Opa1 : Opa0;
                Mul_Opb <= gnt_idx ? Opb1 : Opb0;
            end
            if (state == LOAD) begin
                cnt <= CW'(MUL_LAT - 1);
            end else if ((state == RUN) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if ((state == RUN) && (cnt == '0)) begin
                Rsp_Prod <= Mul_Prod;
            end else if ((state == IDLE) && acked && zero_job) begin
                Rsp_Prod <= '0;
            end
        end
    end

    assign Mul_LoadB  = (state == LOAD);
    assign Mul_Run    = (state == RUN);
    assign Rsp_Valid0 = (state == RESP) && (owner == 1'b0);
    assign Rsp_Valid1 = (state == RESP) && (owner == 1'b1);

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-client scheduler for the shared 8-bit shift-add multiplier datapath. Arbitrates round-robin between two requesters and sequences the multiplier for each job: operand load, a fixed-length run, then drain. It captures the 16-bit product and returns it to the owning client over a valid/ready handshake. Sits between client logic and the multiplier's control inputs (Run, ClearA_LoadB).

## Interface
- MUL_LAT, 18: cycles Mul_Run is held high per job; the product is valid on Mul_Prod in the last of them; legal range ≥1.
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  one clock; reset is synchronous and active-high.
- Req0, Req1  in  1 each  client k requests a multiply; held until acked.
- Opa0, Opb0, Opa1, Opb1  in  8 each  signed two's-complement operands, sampled on ack.
- Req_Ack0, Req_Ack1  out  1 each  one-cycle grant/ack pulse.
- Rsp_Valid0, Rsp_Valid1  out  1 each  product available for client k.
- Rsp_Ready0, Rsp_Ready1  in  1 each  client k accepts product.
- Rsp_Prod  out  16  product; shared by both clients, qualified by Rsp_Valid_k.
- Mul_Opa, Mul_Opb  out  8 each  registered operands to the datapath, stable for the whole job.
- Mul_LoadB  out  1  one-cycle pulse to the multiplier's ClearA_LoadB.
- Mul_Run  out  1  multiplier Run.
- Mul_Prod  in  16  multiplier result.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP.
- IDLE: if any Req_k is high, grant per round-robin, pulse Req_Ack_k, register operands and owner, then go to LOAD. Otherwise stay in IDLE.
- Round-robin: a last-grant pointer selects. On a tie, grant the client not granted last. Reset makes client 0 win the first tie.
- A lone requester is always granted, regardless of the pointer.
- LOAD: Mul_LoadB=1 for one cycle, then RUN.
- RUN: Mul_Run=1. The counter loads MUL_LAT-1 on entry and decrements. When it reaches 0, register Mul_Prod into Rsp_Prod and go to DRAIN.
- DRAIN: Mul_Run=0 for one cycle so the multiplier returns to its idle state, then RESP.
- RESP: Rsp_Valid_owner=1 while Rsp_Prod holds steady. On the cycle Rsp_Valid_owner and Rsp_Ready_owner are both high, go to IDLE. Rsp_Valid for the other client stays 0.
- Arbitration happens only in IDLE. A client re-requesting while its response is pending waits for IDLE.
- Requests arriving during a job are held by the client. None are dropped or queued internally.
- Rsp_Ready_k without a matching Rsp_Valid_k is ignored.
- Arithmetic: this block computes nothing; the product is passed through unmodified as a 16-bit two's-complement value. Counter width is $clog2(MUL_LAT+1).

## Timing
- Reset values:
  - state=IDLE; last-grant pointer = client 1.
  - All Req_Ack, Rsp_Valid, Mul_LoadB and Mul_Run outputs are 0.
  - Rsp_Prod, Mul_Opa and Mul_Opb are 0.
- Reset mid-job (any state) aborts the job: Mul_Run drops the next cycle, the product is discarded, and no response is issued.
- Per-job timeline, with the grant in cycle T:
  - Req_Ack@T.
  - Mul_LoadB@T+1.
  - Mul_Run@T+2..T+1+MUL_LAT.
  - DRAIN@T+2+MUL_LAT.
  - Rsp_Valid from T+3+MUL_LAT.
- Latency from grant to first Rsp_Valid is MUL_LAT+3 cycles.
- Earliest next grant is the cycle after the response handshake, so back-to-back jobs cost MUL_LAT+4 cycles each with zero backpressure.
- All outputs are registered or decoded from state only; there is no combinational path from a Req or Rsp_Ready input to an output.

## Configuration
- MULT_SCHED_ZERO_BYPASS_EN defined: in IDLE, a granted job with Opa==0 or Opb==0 skips LOAD, RUN and DRAIN. It goes directly to RESP the cycle after the ack with Rsp_Prod=0, and Mul_Run and Mul_LoadB stay 0.
- MULT_SCHED_ZERO_BYPASS_EN not defined: every job runs the full sequence.

## Structure
- Package mult_sched_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN, RESP);
  - the client index typedef (1 bit);
  - the MUL_LAT_DEFAULT=18 constant.
- Sub-module rr_arb2: two-way round-robin arbiter. Inputs are the requests, the pointer and an enable (state==IDLE); outputs are a one-hot grant and the granted index. The pointer update is in rr_arb2.

## Test plan
- Basic multiply: Req0 with Opa0=3, Opb0=5 at T, MUL_LAT=18, Rsp_Ready0 tied 1 → Req_Ack0@T, Mul_LoadB@T+1, Rsp_Valid0@T+21 with Rsp_Prod=0x000F, IDLE@T+22.
- Signed result: Opa1=-2 (0xFE), Opb1=7 → Rsp_Prod=0xFFF2 on Rsp_Valid1, and Rsp_Valid0 stays 0 throughout.
- Tie and fairness: Req0 and Req1 high together from reset → ack order is 0, 1, 0, 1 across four jobs. With only Req1 high, Req1 is granted twice in a row.
- Backpressure: Rsp_Ready0 held 0 for 5 cycles after Rsp_Valid0 rises → Rsp_Valid0 and Rsp_Prod are stable, and Req1 is not acked until the cycle after the handshake.
- Reset during RUN (Reset at T+10) → Mul_Run=0 at T+11, no Rsp_Valid, pointer restored; the next tie grants client 0.
- Zero bypass, with MULT_SCHED_ZERO_BYPASS_EN defined: Opa0=0, Opb0=9 → Rsp_Valid0@T+1 with Rsp_Prod=0 and Mul_Run never asserted. Without the macro, the same stimulus gives Rsp_Valid0@T+21 with Rsp_Prod=0.
